// File: rtl/ysyx_040750_intrctrl_if.sv
// Trap-entry bus between the pipeline (master) and the timer-interrupt controller (slave).
// The master drives the retirement, CSR and IF-handshake inputs and observes the trap outputs.
interface ysyx_040750_intrctrl_if;
  logic        I_timer_intr;
  logic        I_WB_valid;
  logic        I_WB_exc;
  logic [63:0] I_WB_npc;
  logic [63:0] I_mtvec;
  logic        I_redirect_ready;
  logic        O_busy;
  logic        O_flush;
  logic        O_trap_wen;
  logic [63:0] O_mepc;
  logic [63:0] O_mcause;
  logic        O_redirect_valid;
  logic [63:0] O_redirect_pc;
  logic [31:0] O_intr_cnt;

  modport master (
    output I_timer_intr, I_WB_valid, I_WB_exc, I_WB_npc, I_mtvec, I_redirect_ready,
    input  O_busy, O_flush, O_trap_wen, O_mepc, O_mcause,
           O_redirect_valid, O_redirect_pc, O_intr_cnt
  );

  modport slave (
    input  I_timer_intr, I_WB_valid, I_WB_exc, I_WB_npc, I_mtvec, I_redirect_ready,
    output O_busy, O_flush, O_trap_wen, O_mepc, O_mcause,
           O_redirect_valid, O_redirect_pc, O_intr_cnt
  );
endinterface

// File: rtl/ysyx_040750_intrctrl.sv
// Timer-interrupt trap-entry controller: flush the pipe, write mepc/mcause, then redirect IF to mtvec.
// All outputs are registered and decoded from the next state so they change exactly on the state edge.
module ysyx_040750_intrctrl (
  input  logic                           I_sys_clk,
  input  logic                           I_rst_n,
  ysyx_040750_intrctrl_if.slave          bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    CSRWR = 2'd2,
    REDIR = 2'd3
  } state_t;

  typedef struct packed {
    logic busy;
    logic flush;
    logic trap_wen;
    logic redirect_valid;
  } strobes_t;

  localparam logic [63:0] MCAUSE_TIMER = 64'h8000_0000_0000_0007;
  localparam logic [63:0] MTVEC_MASK   = ~64'h0000_0000_0000_0003;

  // Per-state strobe decode shared by the output registers.
  function automatic strobes_t decode_strobes(input state_t st);
    strobes_t s;
    s = '{busy: 1'b0, flush: 1'b0, trap_wen: 1'b0, redirect_valid: 1'b0};
    case (st)
      IDLE:    s = '{busy: 1'b0, flush: 1'b0, trap_wen: 1'b0, redirect_valid: 1'b0};
      FLUSH:   s = '{busy: 1'b1, flush: 1'b1, trap_wen: 1'b0, redirect_valid: 1'b0};
      CSRWR:   s = '{busy: 1'b1, flush: 1'b0, trap_wen: 1'b1, redirect_valid: 1'b0};
      REDIR:   s = '{busy: 1'b1, flush: 1'b0, trap_wen: 1'b0, redirect_valid: 1'b1};
      default: s = '{busy: 1'b0, flush: 1'b0, trap_wen: 1'b0, redirect_valid: 1'b0};
    endcase
    return s;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic        accept_s;
  strobes_t    strobes_nxt_s;
  logic [63:0] mepc_r;
  logic [63:0] redir_pc_r;
  logic [31:0] intr_cnt_r;
  logic        busy_r;
  logic        flush_r;
  logic        trap_wen_r;
  logic        redirect_valid_r;
  logic [63:0] mcause_r;
  logic [63:0] redirect_pc_r;

  // Next-state logic; request inputs only matter while IDLE, so nothing is queued mid-trap.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.I_timer_intr && bus.I_WB_valid && !bus.I_WB_exc) begin
          state_nxt_s = FLUSH;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FLUSH:   state_nxt_s = CSRWR;
      CSRWR:   state_nxt_s = REDIR;
      REDIR: begin
        if (bus.I_redirect_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REDIR;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Strobes for the state being entered, so registered outputs align with the state register.
  always_comb begin
    strobes_nxt_s = decode_strobes(state_nxt_s);
  end

  // State register.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Trap context captured at the accept edge: return PC, aligned vector base and taken count.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mepc_r     <= 64'h0;
      redir_pc_r <= 64'h0;
      intr_cnt_r <= 32'h0;
    end else if (accept_s) begin
      mepc_r     <= bus.I_WB_npc;
      redir_pc_r <= bus.I_mtvec & MTVEC_MASK;
      intr_cnt_r <= intr_cnt_r + 32'd1;
    end else begin
      mepc_r     <= mepc_r;
      redir_pc_r <= redir_pc_r;
      intr_cnt_r <= intr_cnt_r;
    end
  end

  // Output registers; cause and redirect PC are zeroed outside their owning state.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      busy_r           <= 1'b0;
      flush_r          <= 1'b0;
      trap_wen_r       <= 1'b0;
      redirect_valid_r <= 1'b0;
      mcause_r         <= 64'h0;
      redirect_pc_r    <= 64'h0;
    end else begin
      busy_r           <= strobes_nxt_s.busy;
      flush_r          <= strobes_nxt_s.flush;
      trap_wen_r       <= strobes_nxt_s.trap_wen;
      redirect_valid_r <= strobes_nxt_s.redirect_valid;
      mcause_r         <= strobes_nxt_s.trap_wen ? MCAUSE_TIMER : 64'h0;
      redirect_pc_r    <= strobes_nxt_s.redirect_valid ? redir_pc_r : 64'h0;
    end
  end

  assign bus.O_busy           = busy_r;
  assign bus.O_flush          = flush_r;
  assign bus.O_trap_wen       = trap_wen_r;
  assign bus.O_mepc           = mepc_r;
  assign bus.O_mcause         = mcause_r;
  assign bus.O_redirect_valid = redirect_valid_r;
  assign bus.O_redirect_pc    = redirect_pc_r;
  assign bus.O_intr_cnt       = intr_cnt_r;

endmodule

// File: tb/tb_ysyx_040750_intrctrl.sv
// Self-checking bench for ysyx_040750_intrctrl: a directed vector table, hand-written
// corner sequences and random stimulus, all scored against a cycle-timeline reference model.
module tb_ysyx_040750_intrctrl;

  logic clk;
  logic rst_n;
  ysyx_040750_intrctrl_if bus ();

  ysyx_040750_intrctrl dut (
    .I_sys_clk (clk),
    .I_rst_n   (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: phase counts cycles since the accept (0 = no trap in progress).
  int          m_phase;
  logic [63:0] m_mepc;
  logic [63:0] m_rpc;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0; m_mepc = 64'h0; m_rpc = 64'h0; m_cnt = 32'h0;
  endtask

  // Advance the model by one clock edge given the inputs sampled at that edge.
  task automatic model_edge(input logic t, input logic v, input logic e,
                            input logic [63:0] npc, input logic [63:0] mtvec, input logic rdy);
    if (m_phase == 0) begin
      if (t && v && !e) begin
        m_phase = 1; m_mepc = npc; m_rpc = {mtvec[63:2], 2'b00}; m_cnt = m_cnt + 32'd1;
      end
    end else if (m_phase < 3) m_phase++;
    else if (rdy) m_phase = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".busy"},  {63'h0, bus.O_busy},           {63'h0, m_phase != 0});
    chk({tag, ".flush"}, {63'h0, bus.O_flush},          {63'h0, m_phase == 1});
    chk({tag, ".wen"},   {63'h0, bus.O_trap_wen},       {63'h0, m_phase == 2});
    chk({tag, ".rv"},    {63'h0, bus.O_redirect_valid}, {63'h0, m_phase == 3});
    chk({tag, ".mepc"},  bus.O_mepc, m_mepc);
    chk({tag, ".mcause"}, bus.O_mcause, (m_phase == 2) ? 64'h8000_0000_0000_0007 : 64'h0);
    chk({tag, ".rpc"},   bus.O_redirect_pc, (m_phase == 3) ? m_rpc : 64'h0);
    chk({tag, ".cnt"},   {32'h0, bus.O_intr_cnt}, {32'h0, m_cnt});
  endtask

  // Drive inputs, clock once, update model and compare #1 after the edge.
  task automatic step(input string tag, input logic t, input logic v, input logic e,
                      input logic [63:0] npc, input logic [63:0] mtvec, input logic rdy);
    bus.I_timer_intr = t; bus.I_WB_valid = v; bus.I_WB_exc = e;
    bus.I_WB_npc = npc; bus.I_mtvec = mtvec; bus.I_redirect_ready = rdy;
    @(posedge clk);
    model_edge(t, v, e, npc, mtvec, rdy);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        t, v, e, rdy;
    logic [63:0] npc, mtvec;
    logic        x_flush, x_wen, x_rv, x_busy;
    logic [63:0] x_mepc, x_mcause, x_rpc;
    logic [31:0] x_cnt;
  } vec_t;

  localparam logic [63:0] MC = 64'h8000_0000_0000_0007;
  vec_t vecs[11];
  int   wen_seen;

  initial begin
    rst_n = 1'b0;
    bus.I_timer_intr = 1'b0; bus.I_WB_valid = 1'b0; bus.I_WB_exc = 1'b0;
    bus.I_WB_npc = 64'h0; bus.I_mtvec = 64'h0; bus.I_redirect_ready = 1'b0;
    model_reset();

    //             t     v     e     rdy   npc                   mtvec                 fl    wen   rv    busy  mepc                  mcause  rpc                   cnt
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h8000_0104,        64'h8000_0201,        1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0104,        64'h0, 64'h0,                32'd1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h0,                64'h0,                1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0104,        MC,    64'h0,                32'd1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h1234,             64'h5678,             1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0104,        64'h0, 64'h8000_0200,        32'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h0,                64'h0,                1'b0, 1'b0, 1'b0, 1'b0, 64'h8000_0104,        64'h0, 64'h0,                32'd1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h8000_0200,        64'h8000_0201,        1'b0, 1'b0, 1'b0, 1'b0, 64'h8000_0104,        64'h0, 64'h0,                32'd1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0204,        64'h8000_0201,        1'b0, 1'b0, 1'b0, 1'b0, 64'h8000_0104,        64'h0, 64'h0,                32'd1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0300,        64'h0000_1003,        1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0300,        64'h0, 64'h0,                32'd2};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF,        64'hFFFF_FFFF,        1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0300,        MC,    64'h0,                32'd2};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF,        64'hFFFF_FFFF,        1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0300,        64'h0, 64'h0000_1000,        32'd2};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF,        64'hFFFF_FFFF,        1'b0, 1'b0, 1'b0, 1'b0, 64'h8000_0300,        64'h0, 64'h0,                32'd2};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 64'hFFFF_0000_0000_0040, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_0000_0000_0040, 64'h0, 64'h0, 32'd3};

    #1;
    chk("rst_async.busy", {63'h0, bus.O_busy}, 64'h0);
    chk("rst_async.cnt",  {32'h0, bus.O_intr_cnt}, 64'h0);
    do_reset();

    // Directed table: accept, priority, no-retire, ignored inputs, back-to-back re-accept.
    for (int i = 0; i < 11; i++) begin
      bus.I_timer_intr = vecs[i].t; bus.I_WB_valid = vecs[i].v; bus.I_WB_exc = vecs[i].e;
      bus.I_WB_npc = vecs[i].npc; bus.I_mtvec = vecs[i].mtvec; bus.I_redirect_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.flush", i), {63'h0, bus.O_flush},          {63'h0, vecs[i].x_flush});
      chk($sformatf("vec%0d.wen", i),   {63'h0, bus.O_trap_wen},       {63'h0, vecs[i].x_wen});
      chk($sformatf("vec%0d.rv", i),    {63'h0, bus.O_redirect_valid}, {63'h0, vecs[i].x_rv});
      chk($sformatf("vec%0d.busy", i),  {63'h0, bus.O_busy},           {63'h0, vecs[i].x_busy});
      chk($sformatf("vec%0d.mepc", i),  bus.O_mepc,    vecs[i].x_mepc);
      chk($sformatf("vec%0d.mcause", i), bus.O_mcause, vecs[i].x_mcause);
      chk($sformatf("vec%0d.rpc", i),   bus.O_redirect_pc, vecs[i].x_rpc);
      chk($sformatf("vec%0d.cnt", i),   {32'h0, bus.O_intr_cnt}, {32'h0, vecs[i].x_cnt});
    end

    // Backpressure: ready low for 5 REDIR cycles, redirect held 6 cycles.
    do_reset();
    step("bp.acc", 1'b1, 1'b1, 1'b0, 64'h8000_0104, 64'h8000_0201, 1'b0);
    step("bp.fl",  1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    step("bp.wr",  1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("bp.hold", 1'b1, 1'b1, 1'b0, 64'h99, 64'h77, 1'b0);
      chk("bp.pc_stable", bus.O_redirect_pc, 64'h8000_0200);
    end
    step("bp.rdy", 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
    chk("bp.idle", {63'h0, bus.O_busy}, 64'h0);

    // No retirement for 10 cycles: never busy.
    for (int i = 0; i < 10; i++) step("noret", 1'b1, 1'b0, 1'b0, 64'h44, 64'h88, 1'b1);

    // Reset during CSRWR: outputs clear at once and the write strobe never appears.
    step("rm.acc", 1'b1, 1'b1, 1'b0, 64'h8000_0500, 64'h8000_0601, 1'b1);
    step("rm.fl",  1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
    chk("rm.in_csrwr", {63'h0, bus.O_trap_wen}, 64'h1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("rm.async");
    @(negedge clk);
    rst_n = 1'b1;
    wen_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step("rm.after", 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
      if (bus.O_trap_wen) wen_seen++;
    end
    chk("rm.no_wen", 64'(wen_seen), 64'h0);

    // Counter wrap from all-ones.
    @(negedge clk);
    force dut.intr_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.intr_cnt_r;
    m_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("wrap.pre", {32'h0, bus.O_intr_cnt}, 64'hFFFF_FFFF);
    step("wrap.acc", 1'b1, 1'b1, 1'b0, 64'h10, 64'h20, 1'b1);
    chk("wrap.zero", {32'h0, bus.O_intr_cnt}, 64'h0);

    // Random stimulus against the model.
    for (int i = 0; i < 2000; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), {$urandom, $urandom}, {$urandom, $urandom},
           1'($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
